// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the shared-ALU arbiter.
//   alu_opcode_t   : operation set of the shared ALU (codes 10..15 are unused
//                    and pass src1 through)
//   alu_operands_t : opcode plus both operands as seen by the ALU
//   out_state_t    : occupancy of the 1-entry output stage
//   alu_compute()  : the combinational ALU itself
package alu_share_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_opcode_t;

  typedef struct packed {
    alu_opcode_t opcode;
    logic [31:0] src1;
    logic [31:0] src2;
  } alu_operands_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Shifts only look at the low five bits of src2; add/sub wrap naturally.
  function automatic logic [31:0] alu_compute(input alu_operands_t op);
    logic [4:0] shamt;
    shamt = op.src2[4:0];
    case (op.opcode)
      ALU_ADD:  alu_compute = op.src1 + op.src2;
      ALU_SUB:  alu_compute = op.src1 - op.src2;
      ALU_AND:  alu_compute = op.src1 & op.src2;
      ALU_OR:   alu_compute = op.src1 | op.src2;
      ALU_XOR:  alu_compute = op.src1 ^ op.src2;
      ALU_SLL:  alu_compute = op.src1 << shamt;
      ALU_SRL:  alu_compute = op.src1 >> shamt;
      ALU_SRA:  alu_compute = $unsigned($signed(op.src1) >>> shamt);
      ALU_SLT:  alu_compute = {31'b0, ($signed(op.src1) < $signed(op.src2))};
      ALU_SLTU: alu_compute = {31'b0, (op.src1 < op.src2)};
      default:  alu_compute = op.src1;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   en        : when low no grant is produced
//   ptr       : highest-priority index this cycle (kept by the parent)
//   grant     : one-hot grant, or zero
//   grant_idx : binary index of the granted requester (0 when none)
//   grant_any : a grant was produced
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    grant_any
);
  localparam int IW = $clog2(NREQ);

  logic [IW:0]   pos;
  logic [IW-1:0] idx;

  // Scan ptr, ptr+1, ... modulo NREQ; the first requester found wins.
  // pos is one bit wider so ptr+k cannot overflow before the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NREQ)) begin
        pos = pos - (IW+1)'(NREQ);
      end
      idx = pos[IW-1:0];
      if (en && !grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NREQ issue ports. A round-robin arbiter picks one
// requester per cycle, its operands go through the ALU, and the result is
// registered with tag and owner in a 1-entry valid/ready output stage.
//   clk, resetn       : clock, asynchronous active-low reset
//   flush             : empties the output stage, blocks this cycle's grant
//   req_valid/ready   : per-requester handshake; req_ready is the one-hot grant
//   req_opcode/src1/src2/tag : per-requester operation
//   resp_valid/ready  : output stage handshake
//   resp_result/tag/owner    : completed operation
//   conflict_cnt      : saturating count of cycles with more than one request
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        flush,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  alu_opcode_t [NREQ-1:0]      req_opcode,
  input  logic [NREQ-1:0][31:0]       req_src1,
  input  logic [NREQ-1:0][31:0]       req_src2,
  input  logic [NREQ-1:0][TAG_W-1:0]  req_tag,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [31:0]                 resp_result,
  output logic [TAG_W-1:0]            resp_tag,
  output logic [$clog2(NREQ)-1:0]     resp_owner,
  output logic [CNT_W-1:0]            conflict_cnt
);
  localparam int IW = $clog2(NREQ);

  out_state_t    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [31:0]   result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic          can_issue;
  logic          grant_any;
  logic [IW-1:0] grant_idx;
  alu_operands_t alu_in;
  logic [31:0]   alu_out;

  assign resp_valid   = (state_q == ST_FULL);
  assign resp_result  = result_q;
  assign resp_tag     = tag_q;
  assign resp_owner   = owner_q;
  assign conflict_cnt = cnt_q;

  // The stage can take a new op when empty or being drained this cycle.
  assign can_issue = !flush && (!resp_valid || resp_ready);

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req       (req_valid),
    .en        (can_issue),
    .ptr       (rr_ptr_q),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Single ALU fed by a grant-indexed operand mux.
  always_comb begin
    alu_in.opcode = req_opcode[grant_idx];
    alu_in.src1   = req_src1[grant_idx];
    alu_in.src2   = req_src2[grant_idx];
  end
  assign alu_out = alu_compute(alu_in);

  // Output stage FSM; flush dominates both drain and grant.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (!flush && grant_any) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (flush)                    state_d = ST_EMPTY;
        else if (grant_any)           state_d = ST_FULL;
        else if (resp_ready)          state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    result_d = result_q;
    tag_d    = tag_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      result_d = alu_out;
      tag_d    = req_tag[grant_idx];
      owner_d  = grant_idx;
      rr_ptr_d = (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Conflicts are counted whether or not anything could be issued.
  always_comb begin
    cnt_d = cnt_q;
    if (($countones(req_valid) > 1) && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      result_q <= '0;
      tag_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: a transaction-level model predicts grants and the
// output stage each cycle; directed literal checks pin the model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int NREQ  = 3;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;
  localparam int IW    = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic resetn, flush, resp_ready;
  logic [NREQ-1:0] req_valid, req_ready;
  alu_opcode_t [NREQ-1:0] req_opcode;
  logic [NREQ-1:0][31:0] req_src1, req_src2;
  logic [NREQ-1:0][TAG_W-1:0] req_tag;
  logic resp_valid;
  logic [31:0] resp_result;
  logic [TAG_W-1:0] resp_tag;
  logic [IW-1:0] resp_owner;
  logic [CNT_W-1:0] conflict_cnt;

  alu_share_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_src1(req_src1), .req_src2(req_src2),
    .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_tag(resp_tag), .resp_owner(resp_owner),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model state
  int          m_ptr;
  bit          m_valid;
  logic [31:0] m_result;
  int          m_tag;
  int          m_owner;
  int          m_cnt;
  int          m_grant;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_alu(input alu_opcode_t op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s;
    s = b % 32;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << s;
      ALU_SRL:  return a >> s;
      ALU_SRA:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      ALU_SLT:  return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
      ALU_SLTU: return {31'b0, (a < b)};
      default:  return a;
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_result = '0; m_tag = 0; m_owner = 0; m_cnt = 0; m_grant = -1;
  endtask

  function automatic int predict();
    int j;
    if (flush || (m_valid && !resp_ready)) return -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge();
    if ($countones(req_valid) > 1 && m_cnt < CNT_MAX) m_cnt++;
    if (flush) begin
      m_valid = 0;
    end else if (m_grant >= 0) begin
      m_valid  = 1;
      m_result = ref_alu(req_opcode[m_grant], req_src1[m_grant], req_src2[m_grant]);
      m_tag    = int'(req_tag[m_grant]);
      m_owner  = m_grant;
      m_ptr    = (m_grant + 1) % NREQ;
      $display("grant req%0d op=%0d tag=%0d result=0x%08h", m_grant,
               req_opcode[m_grant], m_tag, m_result);
    end else if (resp_ready) begin
      m_valid = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    logic [NREQ-1:0] exp_rdy;
    #1;
    m_grant = predict();
    exp_rdy = '0;
    if (m_grant >= 0) exp_rdy[m_grant] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("resp_valid", 64'(resp_valid), 64'(m_valid));
    if (m_valid) begin
      chk("resp_result", 64'(resp_result), 64'(m_result));
      chk("resp_tag", 64'(resp_tag), 64'(m_tag));
      chk("resp_owner", 64'(resp_owner), 64'(m_owner));
    end
    chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input alu_opcode_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t);
    req_opcode[i] = op;
    req_src1[i]   = a;
    req_src2[i]   = b;
    req_tag[i]    = t;
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, alu_opcode_t'(4'($urandom_range(0, 15))),
              ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom(),
              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom(),
              TAG_W'($urandom_range(0, 15)));
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; resp_ready = 1'b0; req_valid = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, ALU_ADD, 32'h0, 32'h0, '0);
    model_reset();

    // Reset values
    @(negedge clk); #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_result", 64'(resp_result), 64'd0);
    chk("rst_tag", 64'(resp_tag), 64'd0);
    chk("rst_owner", 64'(resp_owner), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // T1 single add
    set_req(0, ALU_ADD, 32'd5, 32'd7, 4'd3);
    req_valid = 3'b001; resp_ready = 1'b1;
    #1 chk("t1_ready", 64'(req_ready), 64'b001);
    cycle();
    req_valid = '0;
    #1;
    chk("t1_valid", 64'(resp_valid), 64'd1);
    chk("t1_result", 64'(resp_result), 64'd12);
    chk("t1_tag", 64'(resp_tag), 64'd3);
    chk("t1_owner", 64'(resp_owner), 64'd0);
    cycle();

    // T2 round robin between two requesters
    do_reset();
    randomize_reqs();
    req_valid = 3'b011; resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t2_grant", 64'(req_ready), (k % 2 == 0) ? 64'b001 : 64'b010);
      cycle();
    end
    #1 chk("t2_cnt", 64'(conflict_cnt), 64'd4);

    // T3 backpressure (ptr is 2, so requester 0 wins by wrap)
    set_req(0, ALU_SUB, 32'd3, 32'd5, 4'd5);
    req_valid = 3'b001;
    #1 chk("t3_grant", 64'(req_ready), 64'b001);
    cycle();
    req_valid = 3'b011; resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(1, ALU_XOR, $urandom(), $urandom(), TAG_W'(k));
      #1;
      chk("t3_hold_ready", 64'(req_ready), 64'b000);
      chk("t3_hold_result", 64'(resp_result), 64'hFFFF_FFFE);
      cycle();
    end
    resp_ready = 1'b1;
    #1 chk("t3_release", 64'(req_ready), 64'b010);
    cycle();

    // T4 flush while full with requests pending
    req_valid = 3'b111; resp_ready = 1'b0; flush = 1'b1;
    #1 chk("t4_no_grant", 64'(req_ready), 64'b000);
    cycle();
    flush = 1'b0;
    #1;
    chk("t4_valid", 64'(resp_valid), 64'd0);
    chk("t4_ptr_kept", 64'(req_ready), 64'b100);
    cycle();

    // T5 operations
    resp_ready = 1'b1; req_valid = 3'b001;
    set_req(0, ALU_SRA, 32'h8000_0000, 32'h24, 4'd1);
    cycle();
    #1 chk("t5_sra", 64'(resp_result), 64'hF800_0000);
    set_req(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 4'd2);
    cycle();
    #1 chk("t5_slt", 64'(resp_result), 64'd1);
    set_req(0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 4'd3);
    cycle();
    #1 chk("t5_sltu", 64'(resp_result), 64'd0);
    do_reset();
    req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t5_wrap", 64'(req_ready), 64'(1 << (k % 3)));
      cycle();
    end

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      randomize_reqs();
      req_valid  = NREQ'($urandom());
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      cycle();
    end
    flush = 1'b0;

    // T6 asynchronous reset while full
    resp_ready = 1'b1; req_valid = 3'b011;
    cycle();
    #2 resetn = 1'b0;
    #1;
    chk("t6_valid", 64'(resp_valid), 64'd0);
    chk("t6_cnt", 64'(conflict_cnt), 64'd0);
    chk("t6_result", 64'(resp_result), 64'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1; req_valid = 3'b111;
    #1 chk("t6_first", 64'(req_ready), 64'b001);
    cycle();

    // Counter saturation
    req_valid = 3'b011;
    for (int n = 0; n < 20; n++) begin
      resp_ready = ($urandom_range(0, 1) != 0);
      cycle();
    end
    #1 chk("cnt_sat", 64'(conflict_cnt), 64'(CNT_MAX));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
